tb_sharing_unit: RTL and testbench

// - Testbench-side masking stage: takes unmasked count-bit words plus fresh randomness over two

---
 rtl/tb_sharing_unit.sv | 129 ++++++++++++
 tb/tb_tb_sharing_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_sharing_unit.sv
// tb_sharing_unit: masking stage that turns an unmasked count-bit word plus
// (d-1)*count bits of fresh randomness into a d-share Boolean sharing.
// Share i sits at out_shares[i*count +: count]. Share 0 is the data word XOR
// every random word, and share i (i >= 1) is random word i-1.
// Optional build macro SHARING_CNT_EN adds a 32-bit handshake counter port.
module tb_sharing_unit #(
    parameter int d     = 2,
    parameter int count = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [count-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [(d-1)*count-1:0] rnd_in,
    input  logic                   rnd_valid,
    output logic                   rnd_ready,
    output logic [d*count-1:0]     out_shares,
    output logic                   out_valid,
`ifdef SHARING_CNT_EN
    output logic [31:0]            sharing_cnt,
`endif
    input  logic                   out_ready
);

    // A sharing needs at least two shares to hide anything.
    if (d < 2) begin : g_param_check
        $error("tb_sharing_unit: parameter d must be >= 2");
    end

    // Each input stream has a one-entry skid buffer, so data and randomness
    // can arrive on different cycles and still pair in arrival order.
    logic [count-1:0]       dbuf;
    logic                   dfull;
    logic [(d-1)*count-1:0] rbuf;
    logic                   rfull;
    logic [d*count-1:0]     oreg;
    logic                   oval;

    logic                   data_fire;
    logic                   rnd_fire;
    logic                   d_av;
    logic                   r_av;
    logic                   slot;
    logic                   load;
    logic [count-1:0]       cur_data;
    logic [(d-1)*count-1:0] cur_rnd;
    logic [count-1:0]       share0;
    logic [d*count-1:0]     next_shares;

    // Readies come only from the buffer flags, so there is no combinational
    // path from out_ready back to either input.
    always_comb begin
        in_ready   = !dfull;
        rnd_ready  = !rfull;
        out_shares = oreg;
        out_valid  = oval;
    end

    // Decide whether a new sharing can be formed this cycle and build it from
    // buffered words when present, otherwise from the words on the inputs.
    always_comb begin
        data_fire = in_valid & !dfull;
        rnd_fire  = rnd_valid & !rfull;
        d_av      = dfull | data_fire;
        r_av      = rfull | rnd_fire;
        slot      = !oval | out_ready;
        load      = d_av & r_av & slot;
        cur_data  = dfull ? dbuf : in_data;
        cur_rnd   = rfull ? rbuf : rnd_in;
        share0    = cur_data;
        for (int j = 0; j < d - 1; j++) begin
            share0 = share0 ^ cur_rnd[j*count +: count];
        end
        next_shares = {cur_rnd, share0};
    end

    // Data buffer: captures a word that fired but could not be paired yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbuf  <= '0;
            dfull <= 1'b0;
        end else if (load) begin
            dfull <= 1'b0;
        end else if (data_fire) begin
            dbuf  <= in_data;
            dfull <= 1'b1;
        end
    end

    // Randomness buffer: same holding behaviour as the data buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbuf  <= '0;
            rfull <= 1'b0;
        end else if (load) begin
            rfull <= 1'b0;
        end else if (rnd_fire) begin
            rbuf  <= rnd_in;
            rfull <= 1'b1;
        end
    end

    // Output register: holds the sharing until accepted; a load in the same
    // cycle as an accept replaces it so throughput stays at one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg <= '0;
            oval <= 1'b0;
        end else if (load) begin
            oreg <= next_shares;
            oval <= 1'b1;
        end else if (oval && out_ready) begin
            oval <= 1'b0;
        end
    end

`ifdef SHARING_CNT_EN
    // Count accepted sharings; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sharing_cnt <= '0;
        end else if (oval && out_ready) begin
            sharing_cnt <= sharing_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tb_sharing_unit.sv
// Self-checking bench for tb_sharing_unit: table of same-cycle vectors,
// hand-written skew/stall/reset sequences, a d=3 instance and a random
// back-pressure stream with a pairing scoreboard.
module tb_tb_sharing_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  rnd_in;
    logic        rnd_valid;
    logic        rnd_ready;
    logic [15:0] out_shares;
    logic        out_valid;
    logic        out_ready;

    logic [3:0]  in_data_3;
    logic        in_valid_3;
    logic        in_ready_3;
    logic [7:0]  rnd_in_3;
    logic        rnd_valid_3;
    logic        rnd_ready_3;
    logic [11:0] out_shares_3;
    logic        out_valid_3;
    logic        out_ready_3;

`ifdef SHARING_CNT_EN
    logic [31:0] sharing_cnt;
    logic [31:0] sharing_cnt_3;
`endif

    int checks;
    int errors;

    typedef struct {
        logic [7:0]  data;
        logic [7:0]  rnd;
        logic [15:0] exp_shares;
    } vec_t;

    vec_t vecs [6];

    tb_sharing_unit #(.d(2), .count(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rnd_in     (rnd_in),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .out_shares (out_shares),
        .out_valid  (out_valid),
`ifdef SHARING_CNT_EN
        .sharing_cnt(sharing_cnt),
`endif
        .out_ready  (out_ready)
    );

    tb_sharing_unit #(.d(3), .count(4)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data_3),
        .in_valid   (in_valid_3),
        .in_ready   (in_ready_3),
        .rnd_in     (rnd_in_3),
        .rnd_valid  (rnd_valid_3),
        .rnd_ready  (rnd_ready_3),
        .out_shares (out_shares_3),
        .out_valid  (out_valid_3),
`ifdef SHARING_CNT_EN
        .sharing_cnt(sharing_cnt_3),
`endif
        .out_ready  (out_ready_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] data, input logic dv,
                                  input logic [7:0] rnd, input logic rv,
                                  input logic ordy);
        in_data   = data;
        in_valid  = dv;
        rnd_in    = rnd;
        rnd_valid = rv;
        out_ready = ordy;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Random-stream scoreboard state
    logic [7:0] data_q[$];
    logic [7:0] rnd_q[$];

    initial begin
        logic [7:0]  exp_d;
        logic [7:0]  exp_r;
        logic [15:0] seen;
        logic        fire_d;
        logic        fire_r;
        logic        hs;
        int          n_data;
        int          n_rnd;
        int          n_hs;
        int          cycles;
        logic [7:0]  cur_d;
        logic [7:0]  cur_r;

        checks = 0;
        errors = 0;

        vecs[0] = '{8'hA5, 8'h3C, 16'h3C99};
        vecs[1] = '{8'h00, 8'h00, 16'h0000};
        vecs[2] = '{8'hFF, 8'h00, 16'h00FF};
        vecs[3] = '{8'h00, 8'hFF, 16'hFFFF};
        vecs[4] = '{8'h12, 8'h34, 16'h3426};
        vecs[5] = '{8'hF0, 8'h0F, 16'h0FFF};

        rst_n       = 1'b0;
        in_data_3   = '0;
        in_valid_3  = 1'b0;
        rnd_in_3    = '0;
        rnd_valid_3 = 1'b0;
        out_ready_3 = 1'b1;
        apply_stimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

        // Reset state
        #3;
        check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("reset_rnd_ready", {31'd0, rnd_ready}, 32'd1);
        check_output("reset_out_shares", {16'd0, out_shares}, 32'd0);
`ifdef SHARING_CNT_EN
        check_output("reset_cnt", sharing_cnt, 32'd0);
`endif
        step();
        step();
        rst_n = 1'b1;
        step();

        // Same-cycle vectors from the table
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].data, 1'b1, vecs[i].rnd, 1'b1, 1'b1);
            step();
            check_output($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check_output($sformatf("vec%0d_shares", i), {16'd0, out_shares},
                         {16'd0, vecs[i].exp_shares});
            check_output($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            apply_stimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
            step();
            check_output($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
        end

        // Skewed: data first, randomness three cycles later
        apply_stimulus(8'h01, 1'b1, 8'h00, 1'b0, 1'b1);
        step();
        check_output("skew_in_ready_c1", {31'd0, in_ready}, 32'd0);
        check_output("skew_no_out_c1", {31'd0, out_valid}, 32'd0);
        apply_stimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step();
        check_output("skew_in_ready_c2", {31'd0, in_ready}, 32'd0);
        step();
        check_output("skew_in_ready_c3", {31'd0, in_ready}, 32'd0);
        check_output("skew_no_out_c3", {31'd0, out_valid}, 32'd0);
        apply_stimulus(8'h00, 1'b0, 8'hFF, 1'b1, 1'b1);
        step();
        check_output("skew_valid", {31'd0, out_valid}, 32'd1);
        check_output("skew_shares", {16'd0, out_shares}, 32'h0000FFFE);
        check_output("skew_in_ready_after", {31'd0, in_ready}, 32'd1);
        apply_stimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step();

        // Randomness first, then data
        apply_stimulus(8'h00, 1'b0, 8'h55, 1'b1, 1'b1);
        step();
        check_output("rfirst_rnd_ready", {31'd0, rnd_ready}, 32'd0);
        apply_stimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step();
        check_output("rfirst_no_out", {31'd0, out_valid}, 32'd0);
        apply_stimulus(8'h33, 1'b1, 8'h00, 1'b0, 1'b1);
        step();
        check_output("rfirst_shares", {15'd0, out_valid, out_shares}, 32'h00015566);
        apply_stimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step();

        // Stall: out_ready low for five cycles with both streams offering
        apply_stimulus(8'h10, 1'b1, 8'h40, 1'b1, 1'b0);
        step();
        check_output("stall_c1_valid", {31'd0, out_valid}, 32'd1);
        check_output("stall_c1_shares", {16'd0, out_shares}, 32'h00004050);
        apply_stimulus(8'h11, 1'b1, 8'h41, 1'b1, 1'b0);
        for (int c = 2; c <= 5; c++) begin
            step();
            check_output($sformatf("stall_c%0d_shares", c), {16'd0, out_shares}, 32'h00004050);
            apply_stimulus(8'h12, 1'b1, 8'h42, 1'b1, 1'b0);
        end
        check_output("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check_output("stall_rnd_ready", {31'd0, rnd_ready}, 32'd0);
        check_output("stall_valid", {31'd0, out_valid}, 32'd1);
        apply_stimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step();
        check_output("release_second", {15'd0, out_valid, out_shares}, 32'h00014150);
        check_output("release_readies", {30'd0, in_ready, rnd_ready}, 32'd3);
        step();
        check_output("release_empty", {31'd0, out_valid}, 32'd0);

        // Reset asserted while output and both buffers are occupied
        apply_stimulus(8'h20, 1'b1, 8'h60, 1'b1, 1'b0);
        step();
        apply_stimulus(8'h21, 1'b1, 8'h61, 1'b1, 1'b0);
        step();
        apply_stimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        check_output("pre_rst_full", {29'd0, out_valid, in_ready, rnd_ready}, 32'd4);
        rst_n = 1'b0;
        #1;
        check_output("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("midrst_readies", {30'd0, in_ready, rnd_ready}, 32'd3);
        check_output("midrst_shares", {16'd0, out_shares}, 32'd0);
        step();
        rst_n = 1'b1;
        apply_stimulus(8'h77, 1'b1, 8'h0F, 1'b1, 1'b1);
        step();
        check_output("post_rst_pair", {15'd0, out_valid, out_shares}, 32'h00010F78);
        apply_stimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step();

        // d=3, count=4 instance
        in_data_3   = 4'h6;
        rnd_in_3    = 8'h21;
        in_valid_3  = 1'b1;
        rnd_valid_3 = 1'b1;
        step();
        check_output("d3_shares", {19'd0, out_valid_3, out_shares_3}, 32'h00001215);
        in_valid_3  = 1'b0;
        rnd_valid_3 = 1'b0;
        step();
        check_output("d3_drained", {31'd0, out_valid_3}, 32'd0);

        // Random streams with random back-pressure, scoreboard pairing
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_data = 0;
        n_rnd  = 0;
        n_hs   = 0;
        cycles = 0;
        cur_d  = 8'($urandom);
        cur_r  = 8'($urandom);
        while ((n_hs < 1000) && (cycles < 20000)) begin
            apply_stimulus(cur_d, (n_data < 1000) && ($urandom_range(0, 3) != 0),
                           cur_r, (n_rnd < 1000) && ($urandom_range(0, 3) != 0),
                           $urandom_range(0, 2) != 0);
            fire_d = in_valid & in_ready;
            fire_r = rnd_valid & rnd_ready;
            hs     = out_valid & out_ready;
            seen   = out_shares;
            step();
            cycles++;
            if (hs) begin
                n_hs++;
                if ((data_q.size() == 0) || (rnd_q.size() == 0)) begin
                    check_output("rand_unexpected_out", {16'd0, seen}, 32'hFFFFFFFF);
                end else begin
                    exp_d = data_q.pop_front();
                    exp_r = rnd_q.pop_front();
                    check_output("rand_sharing", {16'd0, seen}, {16'd0, exp_r, exp_d ^ exp_r});
                    check_output("rand_recombine", {24'd0, seen[15:8] ^ seen[7:0]}, {24'd0, exp_d});
                end
            end
            if (fire_d) begin
                data_q.push_back(cur_d);
                n_data++;
                cur_d = 8'($urandom);
            end
            if (fire_r) begin
                rnd_q.push_back(cur_r);
                n_rnd++;
                cur_r = 8'($urandom);
            end
        end
        check_output("rand_handshakes", n_hs, 32'd1000);
        check_output("rand_leftover", data_q.size() + rnd_q.size(), 32'd0);
`ifdef SHARING_CNT_EN
        check_output("rand_sharing_cnt", sharing_cnt, 32'd1000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
